// File: rtl/trace_seq_pkg.sv
// trace_seq_pkg: shared types for the trace sequencer.
// Holds the FSM state enum, cache phase constants and a busy decode helper.
package trace_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SEARCH = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic CACHE_SEARCH = 1'b0;
  localparam logic CACHE_UPDATE = 1'b1;

  function automatic logic is_busy(state_t s);
    return (s == FETCH) || (s == SEARCH) || (s == UPDATE);
  endfunction

endpackage

// File: rtl/trace_sequencer_sat_counter.sv
// sat_counter: W-bit counter that saturates at all-ones, with sync clear.
// Ports: clk, rst (async high), clr, inc, count[W-1:0].
module sat_counter
  import trace_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/trace_sequencer.sv
// trace_sequencer: replays a trace ROM into the cache (search/update) and
// tallies reference/hit/miss counts with saturating counters.
// Ports: clk, rst (async high), start, hold, rom_idx/rom_data (ROM read),
//   cache_addr/cache_state/cache_hit (cache side), busy, done,
//   ref_count, hit_count, miss_count.
// Optional: MISS_CAPTURE_EN adds last_miss_addr (last missing address).
module trace_sequencer
  import trace_seq_pkg::*;
#(
  parameter int TRACE_DEPTH = 57961,
  parameter int ADDR_W      = 32,
  parameter int IDX_W       = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic [IDX_W-1:0]  rom_idx,
  input  logic [ADDR_W-1:0] rom_data,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              cache_state,
  input  logic              cache_hit,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  ref_count,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
`ifdef MISS_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] last_miss_addr
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRACE_DEPTH - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              clr;
  logic              upd;
  logic              hit_inc;
  logic              miss_inc;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    clr     = 1'b0;
    upd     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          clr     = 1'b1;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (!hold) begin
          addr_d  = rom_data;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        state_d = UPDATE;
      end
      UPDATE: begin
        upd = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
    end
  end

  // cache_hit only matters on the closing edge of UPDATE
  assign hit_inc  = upd & cache_hit;
  assign miss_inc = upd & ~cache_hit;

  sat_counter #(.W(CNT_W)) u_ref (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (upd),
    .count (ref_count)
  );

  sat_counter #(.W(CNT_W)) u_hit (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (miss_inc),
    .count (miss_count)
  );

`ifdef MISS_CAPTURE_EN
  logic [ADDR_W-1:0] lma_q, lma_d;

  always_comb begin
    lma_d = lma_q;
    if (clr) begin
      lma_d = '0;
    end else if (miss_inc) begin
      lma_d = addr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lma_q <= '0;
    end else begin
      lma_q <= lma_d;
    end
  end

  assign last_miss_addr = lma_q;
`endif

  assign rom_idx     = idx_q;
  assign cache_addr  = addr_q;
  assign cache_state = (state_q == UPDATE) ? CACHE_UPDATE : CACHE_SEARCH;
  assign busy        = is_busy(state_q);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_trace_sequencer.sv
// tb_trace_sequencer: table-driven and randomized checks of trace_sequencer
// against a timeline model built from the trace/hold/hit description.
module tb_trace_sequencer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        cache_hit = 1'b0;
  logic [15:0] rom_idx;
  logic [31:0] rom_data;
  logic [31:0] cache_addr;
  logic        cache_state;
  logic        busy;
  logic        done;
  logic [15:0] ref_count;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  logic        start2 = 1'b0;
  logic [15:0] idx2;
  logic [31:0] data2;
  logic [31:0] addr2;
  logic        cs2;
  logic        busy2;
  logic        done2;
  logic [1:0]  r2;
  logic [1:0]  h2;
  logic [1:0]  m2;

`ifdef MISS_CAPTURE_EN
  logic [31:0] lma;
  logic [31:0] lma2;
`endif

  logic [31:0] rom [D];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_data = (rom_idx < 16'(D)) ? rom[rom_idx[1:0]] : 32'hDEAD_BEEF;
  assign data2    = 32'h1000 + {16'h0, idx2};

  trace_sequencer #(
    .TRACE_DEPTH (D),
    .ADDR_W      (32),
    .IDX_W       (16),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .hold        (hold),
    .rom_idx     (rom_idx),
    .rom_data    (rom_data),
    .cache_addr  (cache_addr),
    .cache_state (cache_state),
    .cache_hit   (cache_hit),
    .busy        (busy),
    .done        (done),
    .ref_count   (ref_count),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`ifdef MISS_CAPTURE_EN
    ,
    .last_miss_addr (lma)
`endif
  );

  trace_sequencer #(
    .TRACE_DEPTH (6),
    .ADDR_W      (32),
    .IDX_W       (16),
    .CNT_W       (2)
  ) dut2 (
    .clk         (clk),
    .rst         (rst),
    .start       (start2),
    .hold        (1'b0),
    .rom_idx     (idx2),
    .rom_data    (data2),
    .cache_addr  (addr2),
    .cache_state (cs2),
    .cache_hit   (1'b0),
    .busy        (busy2),
    .done        (done2),
    .ref_count   (r2),
    .hit_count   (h2),
    .miss_count  (m2)
`ifdef MISS_CAPTURE_EN
    ,
    .last_miss_addr (lma2)
`endif
  );

  typedef struct {
    int ph;
    int idx;
    bit hd;
  } step_t;

  typedef struct {
    logic [3:0]  hits;
    logic [15:0] hl;
    bit          smid;
    bit          hws;
    int          cyc;
    int          eref;
    int          ehit;
    int          emiss;
    logic [31:0] elma;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model: each reference is (1+hold) FETCH cycles, one SEARCH, one UPDATE.
  task automatic run(input string nm, input vec_t v);
    step_t tl[$];
    step_t s;
    int r = 0;
    int h = 0;
    int m = 0;
    int bc = 0;
    int hn;
    for (int i = 0; i < D; i++) begin
      hn = int'(v.hl[4*i +: 4]);
      for (int k = 0; k <= hn; k++) tl.push_back('{0, i, (k < hn)});
      tl.push_back('{1, i, 1'b0});
      tl.push_back('{2, i, 1'b0});
    end
    start = 1'b1;
    hold  = v.hws;
    @(posedge clk); #1;
    start = 1'b0;
    hold  = 1'b0;
    foreach (tl[c]) begin
      s = tl[c];
      chk($sformatf("%s c%0d cache_state", nm, c), 64'(cache_state), 64'(s.ph == 2));
      chk($sformatf("%s c%0d rom_idx", nm, c), 64'(rom_idx), 64'(s.idx));
      chk($sformatf("%s c%0d done", nm, c), 64'(done), 64'(0));
      chk($sformatf("%s c%0d ref", nm, c), 64'(ref_count), 64'(r));
      chk($sformatf("%s c%0d hit", nm, c), 64'(hit_count), 64'(h));
      chk($sformatf("%s c%0d miss", nm, c), 64'(miss_count), 64'(m));
      if (s.ph != 0)
        chk($sformatf("%s c%0d addr", nm, c), 64'(cache_addr), 64'(rom[s.idx]));
      else if (s.idx > 0)
        chk($sformatf("%s c%0d addr", nm, c), 64'(cache_addr), 64'(rom[s.idx-1]));
      bc += int'(busy);
      hold      = s.hd;
      cache_hit = (s.ph == 2) ? v.hits[s.idx] : 1'($urandom);
      start     = v.smid && (c == 1 || c == 5);
      @(posedge clk); #1;
      if (s.ph == 2) begin
        r++;
        if (v.hits[s.idx]) h++;
        else m++;
      end
    end
    hold  = 1'b0;
    start = 1'b0;
    chk({nm, " busy_cycles"}, 64'(bc), 64'(v.cyc));
    chk({nm, " done"}, 64'(done), 64'(1));
    chk({nm, " busy_end"}, 64'(busy), 64'(0));
    chk({nm, " ref_end"}, 64'(ref_count), 64'(v.eref));
    chk({nm, " hit_end"}, 64'(hit_count), 64'(v.ehit));
    chk({nm, " miss_end"}, 64'(miss_count), 64'(v.emiss));
`ifdef MISS_CAPTURE_EN
    chk({nm, " last_miss"}, 64'(lma), 64'(v.elma));
`endif
    repeat (2) begin
      cache_hit = 1'($urandom);
      @(posedge clk); #1;
      chk({nm, " done_hold"}, 64'(done), 64'(1));
      chk({nm, " ref_hold"}, 64'(ref_count), 64'(v.eref));
      chk({nm, " miss_hold"}, 64'(miss_count), 64'(v.emiss));
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " rom_idx"}, 64'(rom_idx), 64'(0));
    chk({nm, " addr"}, 64'(cache_addr), 64'(0));
    chk({nm, " cache_state"}, 64'(cache_state), 64'(0));
    chk({nm, " busy"}, 64'(busy), 64'(0));
    chk({nm, " done"}, 64'(done), 64'(0));
    chk({nm, " ref"}, 64'(ref_count), 64'(0));
    chk({nm, " hit"}, 64'(hit_count), 64'(0));
    chk({nm, " miss"}, 64'(miss_count), 64'(0));
`ifdef MISS_CAPTURE_EN
    chk({nm, " last_miss"}, 64'(lma), 64'(0));
`endif
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    int n;
    int sum;
    int x;
    rom[0] = 32'h100;
    rom[1] = 32'h104;
    rom[2] = 32'h100;
    rom[3] = 32'h200;

    tbl[0] = '{4'b0100, 16'h0000, 1'b0, 1'b0, 12, 4, 1, 3, 32'h200};
    tbl[1] = '{4'b0100, 16'h0050, 1'b0, 1'b0, 17, 4, 1, 3, 32'h200};
    tbl[2] = '{4'b0100, 16'h0000, 1'b1, 1'b0, 12, 4, 1, 3, 32'h200};
    tbl[3] = '{4'b0100, 16'h0000, 1'b0, 1'b0, 12, 4, 1, 3, 32'h200};
    tbl[4] = '{4'b1111, 16'h0000, 1'b0, 1'b1, 12, 4, 4, 0, 32'h0};
    tbl[5] = '{4'b0000, 16'h1002, 1'b0, 1'b0, 15, 4, 0, 4, 32'h200};

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle busy", 64'(busy), 64'(0));

    for (int i = 0; i < 6; i++) run($sformatf("vec%0d", i), tbl[i]);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(rom_idx == 16'd2 && cache_state) && n < 40) begin
      cache_hit = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    chk("reach idx2 update", 64'(n < 40), 64'(1));
    rst = 1'b1;
    #1;
    chk_zero("midrun_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst idle", 64'(busy), 64'(0));
    run("after_rst", tbl[0]);

    for (int t = 0; t < 8; t++) begin
      rv.hits = 4'($urandom);
      rv.hl   = '0;
      sum     = 0;
      for (int i = 0; i < D; i++) begin
        x = int'($urandom_range(0, 3));
        rv.hl[4*i +: 4] = 4'(x);
        sum += x;
      end
      rv.smid  = 1'($urandom);
      rv.hws   = 1'($urandom);
      rv.cyc   = 3 * D + sum;
      rv.eref  = D;
      rv.ehit  = $countones(rv.hits);
      rv.emiss = D - rv.ehit;
      rv.elma  = '0;
      for (int i = 0; i < D; i++)
        if (!rv.hits[i]) rv.elma = rom[i];
      run($sformatf("rand%0d", t), rv);
    end

    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sat cycles", 64'(n), 64'(18));
    chk("sat ref", 64'(r2), 64'(3));
    chk("sat miss", 64'(m2), 64'(3));
    chk("sat hit", 64'(h2), 64'(0));
`ifdef MISS_CAPTURE_EN
    chk("sat last_miss", 64'(lma2), 64'(32'h1005));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
